// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and constant helpers for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_ASSERT,
    S_RELEASE,
    S_DONE,
    S_IDLE
  } rst_seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rtl/rst_seq_ctrl_if.sv - request inputs and domain reset outputs of the reset sequencer
interface rst_seq_ctrl_if #(
  parameter int N_DOM = 3,
  parameter int N_REQ = 2
);

  logic [N_REQ-1:0] sw_req;
  logic [N_DOM-1:0] domain_rst_n;
  logic             busy;
  logic             seq_done;
  logic [N_REQ-1:0] cause;

  modport master (
    input  sw_req,
    output domain_rst_n,
    output busy,
    output seq_done,
    output cause
  );

  modport slave (
    output sw_req,
    input  domain_rst_n,
    input  busy,
    input  seq_done,
    input  cause
  );

endinterface

// File: rtl/rst_seq_cnt.sv
// rtl/rst_seq_cnt.sv - loadable down-counter with zero flag; saturates at zero
module rst_seq_cnt #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - holds all domains in reset, then releases them in index order with a fixed gap
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_DOM       = 3,
  parameter int N_REQ       = 2,
  parameter int MIN_ASSERT  = 16,
  parameter int RELEASE_GAP = 4
) (
  input  logic            clk,
  input  logic            reset,
  rst_seq_ctrl_if.master  bus
);

  localparam int CNT_W = max_int(1, $clog2(max_int(MIN_ASSERT, RELEASE_GAP)));
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOM - 1);

  rst_seq_state_e   state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [N_DOM-1:0] dom_q;
  logic             busy_q;
  logic             done_q;
  logic [N_REQ-1:0] cause_q;
  logic [N_REQ-1:0] pend_q;
  logic [N_REQ-1:0] req;
  logic             req_any;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  // Released domains always form a contiguous run from bit 0, so a lower index never lags.
  function automatic logic [N_DOM-1:0] therm(input logic [IDX_W-1:0] k);
    logic [N_DOM-1:0] t;
    for (int i = 0; i < N_DOM; i++) begin
      t[i] = (i <= int'(k));
    end
    return t;
  endfunction

  assign req     = bus.sw_req | pend_q;
  assign req_any = |req;
  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = HOLD_LD;
    unique case (state_q)
      S_ASSERT: begin
        if (req_any) begin
          cnt_load = 1'b1;
        end else if (cnt_zero && (N_DOM > 1)) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end
      end
      S_RELEASE: begin
        if (req_any) begin
          cnt_load = 1'b1;
        end else if (cnt_zero && (idx_nxt != LAST_IDX)) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end
      end
      S_IDLE: begin
        cnt_load = req_any;
      end
      S_DONE: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  rst_seq_cnt #(
    .W       (CNT_W),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ASSERT;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      cause_q <= '0;
      pend_q  <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= '0;
      unique case (state_q)
        S_ASSERT: begin
          if (req_any) begin
            cause_q <= cause_q | req;
          end else if (cnt_zero) begin
            idx_q   <= '0;
            dom_q   <= therm('0);
            state_q <= (N_DOM == 1) ? S_DONE : S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (req_any) begin
            idx_q   <= '0;
            dom_q   <= '0;
            cause_q <= cause_q | req;
            state_q <= S_ASSERT;
          end else if (cnt_zero) begin
            idx_q <= idx_nxt;
            dom_q <= therm(idx_nxt);
            if (idx_nxt == LAST_IDX) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // A request arriving now is parked for one cycle and served from S_IDLE.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pend_q  <= bus.sw_req;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (req_any) begin
            dom_q   <= '0;
            busy_q  <= 1'b1;
            cause_q <= req;
            idx_q   <= '0;
            state_q <= S_ASSERT;
          end
        end
      endcase
    end
  end

  assign bus.domain_rst_n = dom_q;
  assign bus.busy         = busy_q;
  assign bus.seq_done     = done_q;
  assign bus.cause        = cause_q;

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer for the register-station subsystem. After power-on reset or a software reset request, it holds a set of downstream reset domains in reset for a minimum time. It then releases them one at a time in ascending index order, with a fixed gap between releases. The domain outputs are active-low so they can drive AXI-style `aresetn` inputs directly. The block also arbitrates reset requests from several requesters and records which one caused the current sequence.

## Interface
- `N_DOM`, 3: number of reset domains; must be ≥1.
- `N_REQ`, 2: number of software reset requesters; must be ≥1.
- `MIN_ASSERT`, 16: cycles all domains are held in reset before the first release; must be ≥1.
- `RELEASE_GAP`, 4: cycles between consecutive domain releases; must be ≥1.
- `clk`  in  1  sole clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw_req`  in  N_REQ  per-requester reset request; each bit is sampled every cycle and is single-cycle-pulse tolerant.
- `domain_rst_n`  out  N_DOM  active-low domain resets; bit 0 is released first.
- `busy`  out  1  high while any domain is held in reset.
- `seq_done`  out  1  one-cycle pulse when the sequence completes.
- `cause`  out  N_REQ  OR of the requests that started or extended the last sequence; all-zero means the sequence came from `reset`.

## Operation
- FSM states: S_ASSERT, S_RELEASE, S_DONE, S_IDLE. All outputs are registered.
- Reset state:
  - FSM enters S_ASSERT; hold counter loads MIN_ASSERT-1.
  - Domain index = 0; `domain_rst_n` = 0; `busy` = 1; `seq_done` = 0; `cause` = 0.
- S_ASSERT:
  - All domains are held low and the counter decrements.
  - When the counter reaches 0, release domain 0 and move to S_RELEASE with the counter = RELEASE_GAP-1.
  - If N_DOM = 1, go straight to S_DONE instead.
- S_RELEASE:
  - The counter decrements.
  - At 0, release domain index+1 and increment the index.
  - Once the last domain is released, go to S_DONE.
- S_DONE: pulse `seq_done`, drop `busy`, go to S_IDLE.
- S_IDLE:
  - `domain_rst_n` is all ones.
  - Any nonzero `sw_req` drives all domains low, sets `busy`, loads `cause` = `sw_req`, loads the hold counter and enters S_ASSERT.
- Request during S_ASSERT: reload the hold counter (the hold is extended) and OR the request into `cause`.
- Request during S_RELEASE: abort the release. Re-assert all domains, reset the index to 0, reload the hold counter, enter S_ASSERT and OR the request into `cause`.
- Request in the same cycle as S_DONE: S_DONE still completes (`seq_done` pulses, `busy` = 0 for that cycle). The request is then handled as an S_IDLE request on the next cycle. Requests are never dropped; they are held in a one-cycle pending register.
- Simultaneous requests from several requesters are accepted together; `cause` gets all of their bits.
- `reset` mid-sequence: immediate return to the reset state, and `cause` is cleared.
- Width rules:
  - Counter width is $clog2(max(MIN_ASSERT, RELEASE_GAP)).
  - Index width is $clog2(N_DOM), minimum 1.
  - No arithmetic wraps; the counter only decrements while nonzero.

## Timing
- Edge 1 is the first rising edge with `reset` = 0.
- `domain_rst_n[k]` rises after edge MIN_ASSERT + k·RELEASE_GAP.
- `seq_done` is high for one cycle after edge MIN_ASSERT + (N_DOM-1)·RELEASE_GAP + 1; `busy` falls on the same edge.
- Software request sampled at edge E: all domains are low after edge E, and the release times above are offset by E.
- Request-to-assert latency is 1 cycle from S_IDLE and 1 cycle during S_RELEASE.
- No output ever glitches high while another domain with a lower index is still low.

## Structure
- Package `rst_seq_pkg`: typedef enum `rst_seq_state_e` {S_ASSERT, S_RELEASE, S_DONE, S_IDLE}.
- Sub-module `rst_seq_cnt`: loadable down-counter with a zero flag, parameterised on width. The hold timer and the gap timer share one instance.
- Top level: FSM, domain index, pending-request register, `cause` register.

## Test plan
- Power-on, defaults (16/4/3): `domain_rst_n` goes 000→001 after edge 16, →011 after edge 20, →111 after edge 24. `seq_done` pulses after edge 25; `cause` = 00.
- From idle, `sw_req` = 10 pulsed at edge 40: all domains are low after edge 40 and released after edges 56/60/64; `cause` = 10.
- `sw_req` = 01 during S_ASSERT, 5 cycles after a request of 10: the hold extends to 16 cycles from the second request and `cause` = 11.
- `sw_req` pulsed 2 cycles after domain 0 releases: `domain_rst_n` returns to 000 the next cycle and the full sequence restarts.
- `sw_req` = 11 in the same cycle as `seq_done`: the pulse completes and all domains are low again one cycle later; `cause` = 11.
- `reset` asserted mid-release: `domain_rst_n` = 000, `busy` = 1 and `cause` = 00 after the next edge; the power-on timing repeats.
